// File: rtl/regfile_poke_pkg.sv
// Shared types and defaults for the register-file poke block.
package regfile_poke_pkg;

  localparam int ENTRIES_DEF = 32;
  localparam int WIDTH_DEF   = 33;
  localparam int AW_DEF      = $clog2(ENTRIES_DEF);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    CHECK,
    ADVANCE
  } state_e;

  // One poke command as seen on the fabric side.
  typedef struct packed {
    logic              bulk;
    logic [AW_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0] data;
  } cmd_t;

endpackage

// File: rtl/regfile_poke_if.sv
// Poke command channel between the debug fabric (master) and the poke block (slave).
interface regfile_poke_if
  import regfile_poke_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic             valid;
  logic             ready;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data;
  logic             bulk;

  modport master (
    output valid,
    output addr,
    output data,
    output bulk,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    input  bulk,
    output ready
  );

endinterface

// File: rtl/regfile_poke_fsm.sv
// Sequencer for the poke block: state register, write strobe, busy and done.
// Optional readback states are built when REGFILE_POKE_VERIFY_EN is defined.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a command; cmd_ready is high only here
//   WRITE   | issue one write for cur_addr, held off by core_stall
//   VERIFY  | readback address presented, tap returns data next cycle
//   CHECK   | readback data compared against the written value
//   ADVANCE | finish a single poke / last bulk entry, or step to next entry
module regfile_poke_fsm
  import regfile_poke_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic cmd_valid,
  input  logic core_stall,
  input  logic cur_bulk,
  input  logic cur_skip,
  input  logic cur_last,
  output logic cmd_ready,
  output logic latch,
  output logic step,
  output logic wr_fire,
  output logic check,
  output logic wr_en,
  output logic busy,
  output logic done
);

  state_e state;

  assign cmd_ready = (state == IDLE);
  assign latch     = cmd_ready && cmd_valid;
  assign wr_fire   = (state == WRITE) && !core_stall && !cur_skip;
  assign check     = (state == CHECK);
  assign step      = (state == ADVANCE) && cur_bulk && !cur_last;

  // State sequencing with registered strobes; wr_en and done are single-cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wr_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= WRITE;
            busy  <= 1'b1;
          end
        end
        WRITE: begin
          // The hardwired entry is skipped entirely, so stall does not matter there.
          if (cur_skip) begin
            state <= ADVANCE;
          end else if (!core_stall) begin
            wr_en <= 1'b1;
`ifdef REGFILE_POKE_VERIFY_EN
            state <= VERIFY;
`else
            state <= ADVANCE;
`endif
          end
        end
        VERIFY:  state <= CHECK;
        CHECK:   state <= ADVANCE;
        ADVANCE: begin
          if (step) begin
            state <= WRITE;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_poke.sv
// Serialises debug-fabric poke commands onto the register-file write port.
// Single pokes and bulk fills (cmd_addr..ENTRIES-1, data incrementing).
// Define REGFILE_POKE_VERIFY_EN to read back every write and flag mismatches.
module regfile_poke
  import regfile_poke_pkg::*;
#(
  parameter  int ENTRIES   = ENTRIES_DEF,
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int SKIP_ZERO = 1,
  localparam int AW        = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset_n,
  regfile_poke_if.slave    cmd,
  input  logic             core_stall,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  logic [AW-1:0]    cur_addr;
  logic [WIDTH-1:0] cur_data;
  logic             cur_bulk;
  logic             cur_skip;
  logic             cur_last;
  logic             latch;
  logic             step;
  logic             wr_fire;
  logic             check;

  assign cur_skip = (SKIP_ZERO != 0) && (cur_addr == '0);
  assign cur_last = (cur_addr == AW'(ENTRIES - 1));

  regfile_poke_fsm u_fsm (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd.valid),
    .core_stall (core_stall),
    .cur_bulk   (cur_bulk),
    .cur_skip   (cur_skip),
    .cur_last   (cur_last),
    .cmd_ready  (cmd.ready),
    .latch      (latch),
    .step       (step),
    .wr_fire    (wr_fire),
    .check      (check),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done)
  );

  // Command capture, bulk stepping and the write address/data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr <= '0;
      cur_data <= '0;
      cur_bulk <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (latch) begin
        cur_addr <= cmd.addr;
        cur_data <= cmd.data;
        cur_bulk <= cmd.bulk;
      end else if (step) begin
        cur_addr <= cur_addr + AW'(1);
        // Pattern wraps modulo 2^WIDTH; the carry out is dropped on purpose.
        cur_data <= cur_data + WIDTH'(1);
      end
      if (wr_fire) begin
        wr_addr <= cur_addr;
        wr_data <= cur_data;
      end
    end
  end

`ifdef REGFILE_POKE_VERIFY_EN
  // Readback address is presented alongside the write so data lands in CHECK;
  // a mismatch takes priority over a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      err     <= 1'b0;
    end else begin
      if (wr_fire) begin
        rd_addr <= cur_addr;
      end
      if (check && (rd_data != cur_data)) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
`else
  logic unused_readback;

  assign rd_addr         = '0;
  assign err             = 1'b0;
  assign unused_readback = ^{rd_data, err_clr, check};
`endif

endmodule
